// File: rtl/boxcar_decimator_pkg.sv
// Shared widths, types and helpers for the boxcar decimator.
// Contents: sample, output and accumulator widths, the decimation exponent type,
// the frame-flag bundle passed from the frame counter to the datapath, and the k clamp.
package boxcar_decimator_pkg;

  localparam int unsigned IN_WIDTH     = 14;
  localparam int unsigned OUT_WIDTH    = 17;
  localparam int unsigned MAX_LOG2_DEC = 7;
  localparam int unsigned K_WIDTH      = 3;
  localparam int unsigned FRAC_BITS    = OUT_WIDTH - IN_WIDTH;

  // The sum of 2^MAX_LOG2_DEC samples needs MAX_LOG2_DEC growth bits.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned max_k);
    return in_w + max_k;
  endfunction

  localparam int unsigned ACC_WIDTH   = acc_width(IN_WIDTH, MAX_LOG2_DEC);
  localparam int unsigned CNT_WIDTH   = MAX_LOG2_DEC;
  localparam int unsigned SCALE_WIDTH = ACC_WIDTH + FRAC_BITS;

  typedef logic [K_WIDTH-1:0] log2_dec_t;

  // Per-cycle frame position of the sample currently on data_i.
  typedef struct packed {
    logic      sample0;
    logic      last;
    log2_dec_t k;
  } frame_flags_t;

  // Exponents above the supported maximum saturate to it.
  function automatic log2_dec_t clamp_k(input log2_dec_t k);
    return (32'(k) > MAX_LOG2_DEC) ? log2_dec_t'(MAX_LOG2_DEC) : k;
  endfunction

endpackage

// File: rtl/boxcar_decimator_if.sv
// Sample-in / averaged-sample-out bundle of the boxcar decimator.
// master: upstream driver (enable_i, sync_i, log2_dec_i, data_i) and consumer of data_o/ce_o.
// slave : the decimator itself.
interface boxcar_decimator_if;
  import boxcar_decimator_pkg::*;

  logic                         enable_i;
  logic                         sync_i;
  log2_dec_t                    log2_dec_i;
  logic signed [IN_WIDTH-1:0]   data_i;
  logic signed [OUT_WIDTH-1:0]  data_o;
  logic                         ce_o;

  modport master (
    output enable_i, sync_i, log2_dec_i, data_i,
    input  data_o, ce_o
  );

  modport slave (
    input  enable_i, sync_i, log2_dec_i, data_i,
    output data_o, ce_o
  );

endinterface

// File: rtl/boxcar_decimator_frame_counter.sv
// Frame sequencing for the boxcar decimator: sample counter and latched exponent.
// Ports: clk_i, rst_i (sync, active high), enable_i, sync_i, log2_dec_i in;
//        flags_c out (combinational: sample0 / last / effective k for the current data_i).
module boxcar_decimator_frame_counter
  import boxcar_decimator_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         sync_i,
  input  log2_dec_t    log2_dec_i,
  output frame_flags_t flags_c
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  log2_dec_t            k_q, k_d;
  logic [CNT_WIDTH-1:0] cur_idx;
  logic [CNT_WIDTH-1:0] term;
  logic [CNT_WIDTH:0]   span;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      k_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      k_q   <= k_d;
    end
  end

  // Frame position decode and next count. A sync restarts the frame at index 0,
  // so a sync coinciding with the old terminal count never raises last for it.
  always_comb begin
    cnt_d   = cnt_q;
    k_d     = k_q;
    flags_c = '0;
    cur_idx = cnt_q;
    span    = '0;
    term    = '0;
    if (!enable_i) begin
      cnt_d = '0;
    end else begin
      if (sync_i || cnt_q == '0) begin
        flags_c.sample0 = 1'b1;
        flags_c.k       = clamp_k(log2_dec_i);
        k_d             = flags_c.k;
        cur_idx         = '0;
      end else begin
        flags_c.k = k_q;
      end
      span         = (CNT_WIDTH+1)'(1) << flags_c.k;
      term         = CNT_WIDTH'(span - (CNT_WIDTH+1)'(1));
      flags_c.last = (cur_idx == term);
      cnt_d        = flags_c.last ? '0 : cur_idx + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/boxcar_decimator.sv
// Boxcar decimator: averages 2^k consecutive signed samples and emits one mean
// with FRAC_BITS fractional bits plus a one-cycle ce_o strobe per frame.
// Ports: clk_i, rst_i (sync, active high), bus (slave modport: enable_i, sync_i,
//        log2_dec_i, data_i in; data_o, ce_o registered out).
module boxcar_decimator
  import boxcar_decimator_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  boxcar_decimator_if.slave   bus
);

  frame_flags_t                  flags_c;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [ACC_WIDTH-1:0]   sample_c;
  logic signed [ACC_WIDTH-1:0]   sum_c;
  logic signed [SCALE_WIDTH-1:0] wide_c;
  logic signed [SCALE_WIDTH-1:0] scaled_c;

  boxcar_decimator_frame_counter u_frame_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (bus.enable_i),
    .sync_i     (bus.sync_i),
    .log2_dec_i (bus.log2_dec_i),
    .flags_c    (flags_c)
  );

  // Sample 0 starts a fresh sum, so the stale accumulator is dropped there.
  assign sample_c = ACC_WIDTH'(bus.data_i);
  assign sum_c    = (flags_c.sample0 ? '0 : acc_q) + sample_c;

  // Mean with fractional bits: (sum <<< FRAC_BITS) >>> k, flooring toward -inf.
  assign wide_c   = SCALE_WIDTH'(sum_c) <<< FRAC_BITS;
  assign scaled_c = wide_c >>> flags_c.k;

  // Accumulator and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      bus.data_o <= '0;
      bus.ce_o   <= 1'b0;
    end else begin
      bus.ce_o <= 1'b0;
      if (!bus.enable_i) begin
        acc_q <= '0;
      end else begin
        acc_q <= sum_c;
        if (flags_c.last) begin
          bus.ce_o   <= 1'b1;
          bus.data_o <= scaled_c[OUT_WIDTH-1:0];
        end
      end
    end
  end

endmodule
